lf_edge_modulator: RTL and testbench



---
 rtl/lf_edge_modulator.sv | 184 ++++++++++++++++++
 tb/tb_lf_edge_modulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lf_edge_modulator.sv
// LF tag-modulation transmitter: buffers ARM bytes, serialises MSB first and
// line-codes them (direct / Manchester / biphase) with carrier-tick bit timing.
module lf_edge_modulator (
  input  logic       pck0,
  input  logic       nreset,
  input  logic       pck_divclk,
  input  logic       enable,
  input  logic [1:0] enc_mode,
  input  logic [7:0] half_period,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       bit_strobe
);
  localparam logic [1:0] ENC_DIRECT     = 2'd0;
  localparam logic [1:0] ENC_MANCHESTER = 2'd1;
  localparam logic [1:0] ENC_BIPHASE    = 2'd2;

  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;

  state_t     state_q, state_d;
  logic [2:0] sync_q;
  logic       tick;
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] hp_q, hp_d;
  logic [1:0] mode_q, mode_d;
  logic       bp_q, bp_d;
  logic       mod_q, mod_d;
  logic       strobe_q, strobe_d;
  logic       load;
  logic [7:0] hp_eff;

  // sync_q[1:0] is the 2-flop synchroniser, sync_q[2] the edge-detect delay
  assign tick       = sync_q[1] & ~sync_q[2];
  assign hp_eff     = (half_period == 8'd0) ? 8'd1 : half_period;
  assign tx_ready   = enable & ~hold_full_q;
  assign busy       = (state_q != IDLE);
  assign mod_out    = mod_q;
  assign bit_strobe = strobe_q;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    hcnt_d      = hcnt_q;
    hp_d        = hp_q;
    mode_d      = mode_q;
    bp_d        = bp_q;
    mod_d       = mod_q;
    strobe_d    = 1'b0;
    load        = 1'b0;

    if (tx_valid && tx_ready) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data;
    end

    if (!enable) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      hold_d      = '0;
      shift_d     = '0;
      bitcnt_d    = '0;
      hcnt_d      = '0;
      bp_d        = 1'b0;
      mod_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mod_d = 1'b0;
          bp_d  = 1'b0;
          if (hold_full_q) load = 1'b1;
        end
        FIRST_HALF: begin
          if (tick) begin
            if (hcnt_q == 8'd1) begin
              hcnt_d  = hp_q;
              state_d = SECOND_HALF;
              case (mode_q)
                ENC_DIRECT:     mod_d = shift_q[7];
                ENC_MANCHESTER: mod_d = ~shift_q[7];
                ENC_BIPHASE: begin
                  if (!shift_q[7]) begin
                    bp_d  = ~bp_q;
                    mod_d = ~bp_q;
                  end
                end
                default:        mod_d = shift_q[7];
              endcase
            end else begin
              hcnt_d = hcnt_q - 8'd1;
            end
          end
        end
        SECOND_HALF: begin
          if (tick) begin
            if (hcnt_q == 8'd1) begin
              if (bitcnt_q != 3'd0) begin
                shift_d  = {shift_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q - 3'd1;
                hcnt_d   = hp_q;
                state_d  = FIRST_HALF;
                strobe_d = 1'b1;
                if (mode_q == ENC_BIPHASE) begin
                  bp_d  = ~bp_q;
                  mod_d = ~bp_q;
                end else begin
                  mod_d = shift_q[6];
                end
              end else if (hold_full_q) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                shift_d = '0;
                mod_d   = 1'b0;
                bp_d    = 1'b0;
              end
            end else begin
              hcnt_d = hcnt_q - 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Loading also covers the back-to-back case, so the half counter
      // restarts right after the tick that closed the previous byte.
      if (load) begin
        hold_full_d = 1'b0;
        shift_d     = hold_q;
        bitcnt_d    = 3'd7;
        hp_d        = hp_eff;
        hcnt_d      = hp_eff;
        mode_d      = enc_mode;
        state_d     = FIRST_HALF;
        strobe_d    = 1'b1;
        if (enc_mode == ENC_BIPHASE) begin
          bp_d  = ~bp_q;
          mod_d = ~bp_q;
        end else begin
          mod_d = hold_q[7];
        end
      end
    end
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      hcnt_q      <= '0;
      hp_q        <= '0;
      mode_q      <= '0;
      bp_q        <= 1'b0;
      mod_q       <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], pck_divclk};
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      hcnt_q      <= hcnt_d;
      hp_q        <= hp_d;
      mode_q      <= mode_d;
      bp_q        <= bp_d;
      mod_q       <= mod_d;
      strobe_q    <= strobe_d;
    end
  end
endmodule

// File: tb/tb_lf_edge_modulator.sv
// Directed bench for lf_edge_modulator: carrier tick every 8 pck0 cycles,
// frames captured as a half-bit level sequence and compared to hand values.
module tb_lf_edge_modulator;
  logic       pck0 = 1'b0;
  logic       nreset = 1'b0;
  logic       pck_divclk = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] enc_mode = 2'd0;
  logic [7:0] half_period = 8'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, mod_out, busy, bit_strobe;

  int checks = 0;
  int failures = 0;

  always #5 pck0 = ~pck0;
  always #40 pck_divclk = ~pck_divclk;

  lf_edge_modulator dut (
    .pck0(pck0), .nreset(nreset), .pck_divclk(pck_divclk), .enable(enable),
    .enc_mode(enc_mode), .half_period(half_period), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .mod_out(mod_out),
    .busy(busy), .bit_strobe(bit_strobe)
  );

  // Call at a negedge; the byte is captured on the following posedge.
  task automatic write_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge pck0);
    #1 tx_valid = 1'b0;
  endtask

  // Records first/second half level of every bit, strobe gaps (from bit 2 on,
  // where ticks are phase-locked to the frame) and the level once idle again.
  task automatic run_frame(input int half_cyc, input int max_cyc,
                           output logic [31:0] halves, output int nstrobe,
                           output int first_lat, output int bad_gap,
                           output logic idle_mod, output bit tmo);
    int last;
    bit seen, done;
    logic prev;
    halves = '0; nstrobe = 0; first_lat = -1; bad_gap = 0;
    idle_mod = 1'bx; tmo = 1'b0; last = 0; seen = 1'b0; done = 1'b0; prev = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge pck0);
      if (bit_strobe) begin
        if (nstrobe == 0) first_lat = cyc;
        else halves = {halves[30:0], prev};
        if (nstrobe >= 2 && (cyc - last) != 2 * half_cyc) bad_gap++;
        last = cyc;
        nstrobe++;
        halves = {halves[30:0], mod_out};
      end
      if (!busy && seen) begin
        halves = {halves[30:0], prev};
        idle_mod = mod_out;
        done = 1'b1;
        break;
      end
      if (busy) seen = 1'b1;
      prev = mod_out;
    end
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset;
    nreset = 1'b0; enable = 1'b0;
    repeat (3) @(negedge pck0);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_disabled got=%b exp=0", tx_ready); end
    enable = 1'b1; #1;
    checks++;
    if ({tx_ready, mod_out, busy, bit_strobe} !== 4'b1000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=1000", {tx_ready, mod_out, busy, bit_strobe});
    end
    @(negedge pck0); nreset = 1'b1;
    repeat (2) @(negedge pck0);
    checks++;
    if ({tx_ready, mod_out, busy, bit_strobe} !== 4'b1000) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=1000", {tx_ready, mod_out, busy, bit_strobe});
    end
  endtask

  task automatic test_direct;
    logic [31:0] h; int ns, lat, bg; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd0; half_period = 8'd4;
    write_byte(8'hA5);
    run_frame(32, 2000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL direct_timeout got=1 exp=0"); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL direct_latency got=%0d exp=2", lat); end
    checks++; if (h[15:0] !== 16'hCC33) begin failures++; $display("FAIL direct_halves got=%h exp=cc33", h[15:0]); end
    checks++; if (ns !== 8) begin failures++; $display("FAIL direct_strobes got=%0d exp=8", ns); end
    checks++; if (bg !== 0) begin failures++; $display("FAIL direct_bit_spacing got=%0d bad exp=0", bg); end
    checks++; if (im !== 1'b0) begin failures++; $display("FAIL direct_idle_level got=%b exp=0", im); end
  endtask

  task automatic test_manchester;
    logic [31:0] h; int ns, lat, bg; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd1; half_period = 8'd2;
    write_byte(8'h80);
    run_frame(16, 1000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL manch_timeout got=1 exp=0"); end
    checks++; if (h[15:0] !== 16'h9555) begin failures++; $display("FAIL manch_halves got=%h exp=9555", h[15:0]); end
    checks++; if (bg !== 0 || ns !== 8) begin failures++; $display("FAIL manch_timing got=%0d/%0d exp=0/8", bg, ns); end
    checks++; if (im !== 1'b0) begin failures++; $display("FAIL manch_idle_level got=%b exp=0", im); end
  endtask

  task automatic test_biphase;
    logic [31:0] h; int ns, lat, bg; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd2; half_period = 8'd1;
    write_byte(8'h0F);
    run_frame(8, 1000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo || h[15:0] !== 16'hAACC) begin failures++; $display("FAIL biphase_0f got=%h exp=aacc", h[15:0]); end
    // 0x7F ends with the level high; the next frame must start from level 0
    @(negedge pck0);
    write_byte(8'h7F);
    run_frame(8, 1000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo || h[15:0] !== 16'hB333) begin failures++; $display("FAIL biphase_7f got=%h exp=b333", h[15:0]); end
    checks++; if (im !== 1'b0) begin failures++; $display("FAIL biphase_idle_level got=%b exp=0", im); end
    @(negedge pck0);
    write_byte(8'h0F);
    run_frame(8, 1000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo || h[15:0] !== 16'hAACC) begin failures++; $display("FAIL biphase_level_reset got=%h exp=aacc", h[15:0]); end
    checks++; if (bg !== 0) begin failures++; $display("FAIL biphase_spacing got=%0d exp=0", bg); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] h; int ns, lat, bg; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd0; half_period = 8'd1;
    write_byte(8'h3C);
    fork
      run_frame(8, 2000, h, ns, lat, bg, im, tmo);
      begin
        int k;
        k = 0;
        do begin @(negedge pck0); k++; end while (!tx_ready && k < 50);
        checks++; if (k !== 2) begin failures++; $display("FAIL b2b_ready_latency got=%0d exp=2", k); end
        enc_mode = 2'd1;
        write_byte(8'hC3);
        repeat (50) @(negedge pck0);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_held got=%b exp=0", tx_ready); end
      end
    join
    enc_mode = 2'd0;
    checks++; if (tmo) begin failures++; $display("FAIL b2b_timeout got=1 exp=0"); end
    checks++; if (h !== 32'h0FF0A55A) begin failures++; $display("FAIL b2b_halves got=%h exp=0ff0a55a", h); end
    checks++; if (ns !== 16 || bg !== 0) begin failures++; $display("FAIL b2b_timing got=%0d strobes %0d bad exp=16/0", ns, bg); end
  endtask

  task automatic test_abort;
    logic [31:0] h; int ns, lat, bg, k, extra; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd0; half_period = 8'd1;
    write_byte(8'hFF);
    ns = 0; k = 0;
    while (ns < 4 && k < 500) begin @(negedge pck0); k++; if (bit_strobe) ns++; end
    checks++; if (ns !== 4) begin failures++; $display("FAIL abort_reach_bit3 got=%0d exp=4", ns); end
    repeat (3) @(negedge pck0);
    enable = 1'b0;
    @(negedge pck0);
    checks++;
    if ({mod_out, busy, tx_ready} !== 3'b000) begin
      failures++; $display("FAIL abort_outputs got=%b exp=000", {mod_out, busy, tx_ready});
    end
    extra = 0;
    repeat (40) begin @(negedge pck0); if (bit_strobe) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL abort_no_strobe got=%0d exp=0", extra); end
    enable = 1'b1;
    @(negedge pck0);
    checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_reenable got=%b%b exp=10", tx_ready, busy); end
    write_byte(8'h01);
    run_frame(8, 1000, h, ns, lat, bg, im, tmo);
    checks++;
    if (tmo || h[15:0] !== 16'h0003 || ns !== 8 || lat !== 2) begin
      failures++; $display("FAIL abort_clean_frame got=%h/%0d/%0d exp=0003/8/2", h[15:0], ns, lat);
    end
  endtask

  task automatic test_zero_period;
    logic [31:0] h; int ns, lat, bg; logic im; bit tmo;
    @(negedge pck0);
    enc_mode = 2'd0; half_period = 8'd0;
    write_byte(8'h80);
    run_frame(8, 1000, h, ns, lat, bg, im, tmo);
    checks++; if (tmo || h[15:0] !== 16'hC000) begin failures++; $display("FAIL zero_halves got=%h exp=c000", h[15:0]); end
    checks++; if (bg !== 0 || ns !== 8) begin failures++; $display("FAIL zero_timing got=%0d/%0d exp=0/8", bg, ns); end
  endtask

  task automatic test_reset_mid;
    @(negedge pck0);
    enc_mode = 2'd0; half_period = 8'd1;
    write_byte(8'hFF);
    repeat (40) @(negedge pck0);
    checks++; if ({busy, mod_out} !== 2'b11) begin failures++; $display("FAIL midreset_precondition got=%b exp=11", {busy, mod_out}); end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({tx_ready, mod_out, busy, bit_strobe} !== 4'b1000) begin
      failures++; $display("FAIL midreset_async got=%b exp=1000", {tx_ready, mod_out, busy, bit_strobe});
    end
    @(negedge pck0); nreset = 1'b1;
    repeat (20) @(negedge pck0);
    checks++;
    if ({tx_ready, mod_out, busy} !== 3'b100) begin
      failures++; $display("FAIL midreset_stays_idle got=%b exp=100", {tx_ready, mod_out, busy});
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_manchester;
    test_biphase;
    test_back_to_back;
    test_abort;
    test_zero_period;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
